// File: rtl/wait_state_memory.sv
// wait_state_memory: word-organised on-chip memory on the processor bus.
// Adds configurable wait states with a ready handshake, detection of
// sequential bursts, little-endian byte and halfword lanes, and aborts for
// out-of-range, misaligned and privilege-violating accesses.
// Ports:
//   clk, n_reset        - clock, asynchronous active-low reset
//   addr, wdata, write  - request address, write data, direction (1 = write)
//   size, prot, trans   - transfer size, protection (bit1 = privileged), type
//   rdata, ready, abort - read data, data-phase handshake, abort flag
module wait_state_memory #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            N_WAIT      = 2,
  parameter int unsigned            S_WAIT      = 0,
  parameter int unsigned            PRIV_BYTES  = 256
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  write,
  input  logic [1:0]            size,
  input  logic [1:0]            prot,
  input  logic [1:0]            trans,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  abort
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned EXT_W = ADDR_WIDTH + 1;
  // One extra bit so region limits near the top of the address space do not wrap
  localparam logic [EXT_W-1:0] BASE_EXT  = EXT_W'(BASE_ADDR);
  localparam logic [EXT_W-1:0] LIMIT_EXT = BASE_EXT + EXT_W'(4 * DEPTH_WORDS);
  localparam logic [EXT_W-1:0] PRIV_EXT  = BASE_EXT + EXT_W'(PRIV_BYTES);
  localparam logic [3:0]       N_WAIT_C  = 4'(N_WAIT);
  localparam logic [3:0]       S_WAIT_C  = 4'(S_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    hist_valid;
  logic [ADDR_WIDTH-1:0]   l_addr;
  logic [31:0]             l_wdata;
  logic                    l_write;
  logic [1:0]              l_size;
  logic                    l_abort;
  logic [IDX_W-1:0]        l_idx;

  logic [31:0]             mem [DEPTH_WORDS];

  // Read lane steering: byte to all four lanes, halfword to both halves
  function automatic logic [31:0] lanes_read(input logic [31:0] w,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {4{b}};
      2'b01:   return {2{h}};
      default: return w;
    endcase
  endfunction

  // Write lane merge: only the addressed lanes change
  function automatic logic [31:0] lanes_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: if (lane[1]) r[31:16] = wd[15:0];
             else         r[15:0]  = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Request decode
  logic [EXT_W-1:0]      addr_ext_c;
  logic [ADDR_WIDTH-1:0] offset_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  misalign_c;
  logic                  abort_c;
  logic                  accept_c;
  logic                  seq_c;
  logic [3:0]            wait_c;
  logic                  mem_we_c;
  logic [31:0]           merged_c;
  logic [31:0]           src_c;
  logic                  unused_c;

  always_comb begin
    addr_ext_c = EXT_W'(addr);
    offset_c   = addr - BASE_ADDR;
    idx_c      = offset_c[IDX_W+1:2];
    case (size)
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = addr[0];
      2'b10:   misalign_c = (addr[1:0] != 2'b00);
      default: misalign_c = 1'b1;
    endcase
    abort_c  = (addr_ext_c < BASE_EXT) || (addr_ext_c >= LIMIT_EXT) || misalign_c ||
               (!prot[1] && (addr_ext_c < PRIV_EXT));
    accept_c = ready && trans[1];
    // Honoured only when it continues an accepted, non-aborted transfer
    seq_c    = hist_valid && (trans == 2'b11) && !l_abort &&
               (addr == ADDR_WIDTH'(l_addr + (ADDR_WIDTH'(1) << l_size)));
    wait_c   = abort_c ? 4'd0 : (seq_c ? S_WAIT_C : N_WAIT_C);
    mem_we_c = (state == ST_DATA) && l_write && !l_abort;
    merged_c = lanes_merge(mem[l_idx], l_wdata, l_size, l_addr[1:0]);
    // A zero-wait read accepted as a write's data phase ends must see that write
    src_c    = (mem_we_c && (idx_c == l_idx)) ? merged_c : mem[idx_c];
    unused_c = ^{prot[0], offset_c};
  end

  // Storage: not reset, written on the edge that ends a write data phase
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[l_idx] <= merged_c;
  end

  // Transfer FSM with registered bus outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      ready      <= 1'b1;
      abort      <= 1'b0;
      rdata      <= 32'd0;
      hist_valid <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= 32'd0;
      l_write    <= 1'b0;
      l_size     <= 2'b00;
      l_abort    <= 1'b0;
      l_idx      <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state <= ST_DATA;
            ready <= 1'b1;
            if (!l_write) rdata <= lanes_read(mem[l_idx], l_size, l_addr[1:0]);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (accept_c) begin
            hist_valid <= 1'b1;
            l_addr     <= addr;
            l_wdata    <= wdata;
            l_write    <= write;
            l_size     <= size;
            l_abort    <= abort_c;
            l_idx      <= idx_c;
            if (wait_c == 4'd0) begin
              state <= ST_DATA;
              ready <= 1'b1;
              abort <= abort_c;
              if (!abort_c && !write) rdata <= lanes_read(src_c, size, addr[1:0]);
            end else begin
              state <= ST_WAIT;
              ready <= 1'b0;
              abort <= 1'b0;
              cnt   <= wait_c;
            end
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            abort <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench for wait_state_memory with default parameters
// (BASE_ADDR=0, 1024 words, N_WAIT=2, S_WAIT=0, PRIV_BYTES=256).
module tb_wait_state_memory;

  logic        clk;
  logic        n_reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic [1:0]  size;
  logic [1:0]  prot;
  logic [1:0]  trans;
  logic [31:0] rdata;
  logic        ready;
  logic        abort;

  int total = 0;
  int bad   = 0;

  wait_state_memory dut (
    .clk(clk), .n_reset(n_reset), .addr(addr), .wdata(wdata), .write(write),
    .size(size), .prot(prot), .trans(trans), .rdata(rdata), .ready(ready),
    .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  size;
    logic [1:0]  prot;
    logic [1:0]  trans;
    int          ewaits;
    logic [31:0] erdata;
    logic        chk_rd;
    logic        eabort;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;
  localparam logic [1:0] PV = 2'b11, US = 2'b01, UO = 2'b00, PO = 2'b10;
  localparam logic [1:0] TN = 2'b10, TS = 2'b11;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                              input logic [1:0] sz, input logic [1:0] pr, input logic [1:0] tr,
                              input int ew, input logic [31:0] er, input logic cr,
                              input logic ea);
    vec_t v;
    v.addr = a; v.wdata = wd; v.write = wr; v.size = sz; v.prot = pr; v.trans = tr;
    v.ewaits = ew; v.erdata = er; v.chk_rd = cr; v.eabort = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one transfer; return after sampling its data phase (ready back to 1)
  task automatic xfer(input vec_t v, output int waits, output logic [31:0] rd,
                      output logic ab, output logic timeout);
    addr = v.addr; wdata = v.wdata; write = v.write;
    size = v.size; prot = v.prot; trans = v.trans;
    @(posedge clk); #1;
    waits = 0;
    while (ready !== 1'b1 && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    timeout = (ready !== 1'b1);
    rd = rdata;
    ab = abort;
    trans = 2'b00;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int          w;
    logic [31:0] rd;
    logic        ab;
    logic        to;
    xfer(v, w, rd, ab, to);
    check({tag, " timeout"}, 32'(to), 32'd0);
    check({tag, " waits"}, 32'(w), 32'(v.ewaits));
    check({tag, " abort"}, 32'(ab), 32'(v.eabort));
    if (v.chk_rd) check({tag, " rdata"}, rd, v.erdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;

    n_reset = 1'b0;
    addr = '0; wdata = '0; write = 1'b0; size = 2'b00; prot = 2'b00; trans = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset abort", 32'(abort), 32'd0);
    check("reset rdata", rdata, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;

    //              addr       wdata        wr  size  prot trans waits rdata       chk abort
    vecs.push_back(mk(32'h100, 32'hDEADBEEF, 1, SZ_W, PV, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'h100, 32'h0,        0, SZ_W, PV, TN, 2, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(32'h101, 32'h000000AA, 1, SZ_B, PV, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'h102, 32'h0,        0, SZ_H, PV, TN, 2, 32'hDEADDEAD, 1, 0));
    vecs.push_back(mk(32'h101, 32'h0,        0, SZ_B, PV, TN, 2, 32'hAAAAAAAA, 1, 0));
    vecs.push_back(mk(32'h104, 32'h11223344, 1, SZ_W, PV, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'h10C, 32'h55667788, 1, SZ_W, PV, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'h100, 32'h0,        0, SZ_W, PV, TN, 2, 32'hDEADAAEF, 1, 0));
    vecs.push_back(mk(32'h104, 32'h0,        0, SZ_W, PV, TS, 0, 32'h11223344, 1, 0));
    vecs.push_back(mk(32'h10C, 32'h0,        0, SZ_W, PV, TS, 2, 32'h55667788, 1, 0));
    vecs.push_back(mk(32'h102, 32'h0,        0, SZ_W, PV, TN, 0, 32'h55667788, 1, 1));
    vecs.push_back(mk(32'h101, 32'h0000FFFF, 1, SZ_H, PV, TN, 0, 32'h55667788, 1, 1));
    vecs.push_back(mk(32'h1000,32'h0,        0, SZ_W, PV, TN, 0, 32'h55667788, 1, 1));
    vecs.push_back(mk(32'h100, 32'h0,        0, SZ_X, PV, TN, 0, 32'h55667788, 1, 1));
    vecs.push_back(mk(32'h100, 32'h0,        0, SZ_W, PV, TN, 2, 32'hDEADAAEF, 1, 0));
    vecs.push_back(mk(32'h0FC, 32'h0,        0, SZ_W, US, TN, 0, 32'hDEADAAEF, 1, 1));
    vecs.push_back(mk(32'h100, 32'h0,        0, SZ_W, PV, TS, 2, 32'hDEADAAEF, 1, 0));
    vecs.push_back(mk(32'h010, 32'hCAFEF00D, 1, SZ_W, PV, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'h010, 32'h12345678, 1, SZ_W, UO, TN, 0, 32'h0,        0, 1));
    vecs.push_back(mk(32'h010, 32'h0,        0, SZ_W, PV, TN, 2, 32'hCAFEF00D, 1, 0));
    vecs.push_back(mk(32'h010, 32'h12345678, 1, SZ_W, PO, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'h010, 32'h0,        0, SZ_W, PV, TN, 2, 32'h12345678, 1, 0));
    vecs.push_back(mk(32'h104, 32'h0,        0, SZ_W, US, TN, 2, 32'h11223344, 1, 0));
    vecs.push_back(mk(32'h200, 32'h01020304, 1, SZ_W, PV, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'h200, 32'h000000FF, 1, SZ_B, PV, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'h201, 32'h0,        0, SZ_B, PV, TS, 0, 32'h03030303, 1, 0));
    vecs.push_back(mk(32'h202, 32'h0,        0, SZ_H, PV, TS, 0, 32'h01020102, 1, 0));
    vecs.push_back(mk(32'hFFC, 32'h89ABCDEF, 1, SZ_W, PV, TN, 2, 32'h0,        0, 0));
    vecs.push_back(mk(32'hFFC, 32'h0,        0, SZ_W, PV, TN, 2, 32'h89ABCDEF, 1, 0));
    vecs.push_back(mk(32'h1003,32'h0,        0, SZ_B, PV, TN, 0, 32'h89ABCDEF, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Idle and coprocessor cycles: no access, outputs steady
    for (int i = 0; i < 4; i++) begin
      trans = (i < 2) ? 2'b00 : 2'b01;
      addr = 32'h100; write = 1'b1; wdata = 32'hFFFFFFFF; size = SZ_W; prot = PV;
      @(posedge clk); #1;
      check($sformatf("idle%0d ready", i), 32'(ready), 32'd1);
      check($sformatf("idle%0d abort", i), 32'(abort), 32'd0);
      check($sformatf("idle%0d rdata", i), rdata, 32'h89ABCDEF);
    end
    trans = 2'b00;
    run_vec("after idle", mk(32'h100, 32'h0, 0, SZ_W, PV, TN, 2, 32'hDEADAAEF, 1, 0));

    // Reset during the wait of a write: transfer dropped, word unchanged
    run_vec("rst pre", mk(32'h300, 32'h13579BDF, 1, SZ_W, PV, TN, 2, 32'h0, 0, 0));
    addr = 32'h300; wdata = 32'hFFFFFFFF; write = 1'b1; size = SZ_W; prot = PV; trans = TN;
    @(posedge clk); #1;
    check("rst in wait ready", 32'(ready), 32'd0);
    n_reset = 1'b0;
    #1;
    check("rst async ready", 32'(ready), 32'd1);
    check("rst async abort", 32'(abort), 32'd0);
    check("rst async rdata", rdata, 32'd0);
    trans = 2'b00;
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;
    // First transfer after reset is non-sequential even when marked S
    v = mk(32'h300, 32'h0, 0, SZ_W, PV, TS, 2, 32'h13579BDF, 1, 0);
    run_vec("rst post", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
